// File: rtl/irq_pkg.sv
// Shared types and defaults for the interrupt controller.
// Dispatch state enum, default addresses and the vector helper.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SAMPLE,
        DISPATCH
    } irq_state_t;

    localparam logic [7:0]  VEC_BASE_DEF   = 8'h40;
    localparam int unsigned VEC_STRIDE_DEF = 3;
    localparam logic [15:0] IE_ADDR_DEF    = 16'hFFFF;
    localparam logic [15:0] IF_ADDR_DEF    = 16'hFF0F;

    // 8-bit vector, wraps mod 256
    function automatic logic [7:0] vec_of(
        input logic [2:0]  idx,
        input logic [7:0]  base,
        input int unsigned sh
    );
        logic [7:0] off;
        off = {5'b0, idx} << sh;
        return base + off;
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// Bus and sequencer signals of the interrupt controller.
// slave = controller side, master = core/sequencer side.
interface irq_controller_if #(
    parameter int NUM_IRQ = 5
);
    import irq_pkg::*;

    logic [15:0]        A;
    logic [7:0]         DL_in;
    logic               WR;
    logic               RD;
    logic [7:0]         DL_out;
    logic               DL_oe;
    logic [NUM_IRQ-1:0] IRQ_TRIG;
    logic               IME;
    logic               ACK_REQ;
    logic               IRQ_PEND;
    logic               ACK_VALID;
    logic [NUM_IRQ-1:0] CPU_IRQ_ACK;
    logic [7:0]         VECTOR;

    modport slave (
        input  A, DL_in, WR, RD, IRQ_TRIG, IME, ACK_REQ,
        output DL_out, DL_oe, IRQ_PEND, ACK_VALID,
        output CPU_IRQ_ACK, VECTOR
    );

    modport master (
        output A, DL_in, WR, RD, IRQ_TRIG, IME, ACK_REQ,
        input  DL_out, DL_oe, IRQ_PEND, ACK_VALID,
        input  CPU_IRQ_ACK, VECTOR
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Lowest-index-first priority encoder.
// Gives the winning bit one-hot, its index and an any flag.
module irq_prio_enc #(
    parameter int N = 5
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] oh_o,
    output logic [2:0]   idx_o,
    output logic         any_o
);

    // scan from the top so the lowest set bit is written last
    always_comb begin
        oh_o  = '0;
        idx_o = '0;
        any_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                oh_o    = '0;
                oh_o[i] = 1'b1;
                idx_o   = 3'(i);
                any_o   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// IE/IF registers, request edge capture and dispatch FSM.
// Optional macro IRQ_CANCEL_EN: re-pick the winner in DISPATCH.
import irq_pkg::*;

module irq_controller #(
    parameter int          NUM_IRQ         = 5,
    parameter logic [7:0]  VEC_BASE        = VEC_BASE_DEF,
    parameter int unsigned VEC_STRIDE_LOG2 = VEC_STRIDE_DEF,
    parameter logic [15:0] IE_ADDR         = IE_ADDR_DEF,
    parameter logic [15:0] IF_ADDR         = IF_ADDR_DEF
) (
    input logic             CLK,
    input logic             nRES,
    irq_controller_if.slave bus
);

    localparam int N = NUM_IRQ;

    logic [N-1:0] trig_q, ie_q, if_q, ie_d, if_d;
    logic [N-1:0] set_v, pend, enc_oh, disp_oh, clr;
    logic [2:0]   enc_idx;
    logic         enc_any;
    logic [7:0]   disp_vec, ie_rd, if_rd;
    logic         hit_ie, hit_if, ack_q;
    irq_state_t   state_q;

    assign hit_ie = (bus.A == IE_ADDR);
    assign hit_if = (bus.A == IF_ADDR);
    assign set_v  = bus.IRQ_TRIG & ~trig_q;
    assign pend   = ie_q & if_q;

    irq_prio_enc #(.N(N)) u_enc (
        .req_i (pend),
        .oh_o  (enc_oh),
        .idx_o (enc_idx),
        .any_o (enc_any)
    );

`ifdef IRQ_CANCEL_EN
    assign disp_oh  = ack_q ? enc_oh : '0;
    assign disp_vec = (ack_q && enc_any)
                    ? vec_of(enc_idx, VEC_BASE, VEC_STRIDE_LOG2)
                    : 8'h00;
`else
    logic [N-1:0] win_q;
    logic [7:0]   vec_q;

    // latch winner and its vector in SAMPLE, drop after DISPATCH
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            win_q <= '0;
            vec_q <= 8'h00;
        end else if (state_q == SAMPLE) begin
            win_q <= enc_oh;
            vec_q <= enc_any
                   ? vec_of(enc_idx, VEC_BASE, VEC_STRIDE_LOG2)
                   : 8'h00;
        end else if (state_q == DISPATCH) begin
            win_q <= '0;
            vec_q <= 8'h00;
        end
    end

    assign disp_oh  = win_q;
    assign disp_vec = vec_q;
`endif

    assign clr = (state_q == DISPATCH) ? disp_oh : '0;

    // IF precedence: new edge, then dispatch clear, then CPU write
    always_comb begin
        ie_d = ie_q;
        if_d = if_q;
        if (bus.WR && hit_ie) ie_d = bus.DL_in[N-1:0];
        if (bus.WR && hit_if) if_d = bus.DL_in[N-1:0];
        if_d = (if_d & ~clr) | set_v;
    end

    // registers and request edge history
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            trig_q <= '0;
            ie_q   <= '0;
            if_q   <= '0;
        end else begin
            trig_q <= bus.IRQ_TRIG;
            ie_q   <= ie_d;
            if_q   <= if_d;
        end
    end

    // dispatch FSM; ack_q is high exactly in DISPATCH
    always_ff @(posedge CLK or negedge nRES) begin
        if (!nRES) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.ACK_REQ && bus.IME && |pend)
                        state_q <= SAMPLE;
                end
                SAMPLE: begin
                    state_q <= DISPATCH;
                    ack_q   <= 1'b1;
                end
                DISPATCH: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    // unimplemented high bits read back as 1
    always_comb begin
        ie_rd        = 8'hFF;
        if_rd        = 8'hFF;
        ie_rd[N-1:0] = ie_q;
        if_rd[N-1:0] = if_q;
    end

    assign bus.DL_out      = hit_ie ? ie_rd : (hit_if ? if_rd : 8'h00);
    assign bus.DL_oe       = bus.RD && (hit_ie || hit_if);
    assign bus.IRQ_PEND    = |pend;
    assign bus.ACK_VALID   = ack_q;
    assign bus.CPU_IRQ_ACK = disp_oh;
    assign bus.VECTOR      = disp_vec;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller (NUM_IRQ=5).
// Table vectors, directed corner sequences, random vs model.
module tb_irq_controller;

    localparam logic [15:0] IEA = 16'hFFFF;
    localparam logic [15:0] IFA = 16'hFF0F;

    logic CLK = 1'b0;
    logic nRES;
    int   total = 0;
    int   bad   = 0;

    always #5 CLK = ~CLK;

    irq_controller_if #(.NUM_IRQ(5)) bus ();

    irq_controller #(
        .NUM_IRQ(5),
        .VEC_BASE(8'h40),
        .VEC_STRIDE_LOG2(3),
        .IE_ADDR(IEA),
        .IF_ADDR(IFA)
    ) dut (
        .CLK  (CLK),
        .nRES (nRES),
        .bus  (bus)
    );

    typedef struct {
        logic [15:0] a;
        logic        wr;
        logic        rd;
        logic [7:0]  dl;
        logic [4:0]  trig;
        logic [7:0]  e_dl;
        logic        e_oe;
        logic        e_pend;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        bus.A     = a;
        bus.DL_in = d;
        bus.WR    = 1'b1;
        nxt();
        bus.WR    = 1'b0;
    endtask

    task automatic rd_chk(input string nm, input logic [15:0] a,
                          input logic [7:0] exp);
        bus.A  = a;
        bus.RD = 1'b1;
        @(negedge CLK);
        chk(nm, bus.DL_out, exp);
        nxt();
        bus.RD = 1'b0;
    endtask

    // ACK_REQ pulse in cycle n; returns at the drive point of n+1
    task automatic kick();
        bus.ACK_REQ = 1'b1;
        @(negedge CLK);
        chk("kick_n_noack", bus.ACK_VALID, 1'b0);
        nxt();
        bus.ACK_REQ = 1'b0;
    endtask

    function automatic int lowest(input logic [4:0] v);
        for (int i = 0; i < 5; i++)
            if (v[i]) return i;
        return -1;
    endfunction

    initial begin
        int acks;
        int acc, mw, d, cyc;
        logic [4:0] mie, mif, mprev, nif, e_oh;
        logic [7:0] e_vec, e_dl;
        logic e_pend, e_ack, e_oe;
        logic [23:0] got, exp;

        tbl[0]  = '{IFA, 0, 1, 8'h00, 5'h00, 8'hE0, 1, 0};
        tbl[1]  = '{IEA, 1, 0, 8'h1F, 5'h00, 8'hE0, 0, 0};
        tbl[2]  = '{IEA, 0, 1, 8'h00, 5'h00, 8'hFF, 1, 0};
        tbl[3]  = '{IFA, 0, 1, 8'h00, 5'h03, 8'hE0, 1, 0};
        tbl[4]  = '{IFA, 0, 1, 8'h00, 5'h03, 8'hE3, 1, 1};
        tbl[5]  = '{IFA, 1, 0, 8'h00, 5'h03, 8'hE3, 0, 1};
        tbl[6]  = '{IFA, 0, 1, 8'h00, 5'h00, 8'hE0, 1, 0};
        tbl[7]  = '{16'h1234, 0, 1, 8'h00, 5'h00, 8'h00, 0, 0};
        tbl[8]  = '{IEA, 1, 0, 8'h02, 5'h10, 8'hFF, 0, 0};
        tbl[9]  = '{IFA, 0, 1, 8'h00, 5'h10, 8'hF0, 1, 0};
        tbl[10] = '{IFA, 1, 0, 8'h02, 5'h10, 8'hF0, 0, 0};
        tbl[11] = '{IFA, 0, 1, 8'h00, 5'h00, 8'hE2, 1, 1};

        // reset with all requests high
        nRES         = 1'b0;
        bus.A        = IFA;
        bus.DL_in    = 8'h00;
        bus.WR       = 1'b0;
        bus.RD       = 1'b1;
        bus.IRQ_TRIG = 5'h1F;
        bus.IME      = 1'b1;
        bus.ACK_REQ  = 1'b1;
        repeat (2) @(negedge CLK);
        chk("rst_if", bus.DL_out, 8'hE0);
        chk("rst_out", {bus.ACK_VALID, bus.CPU_IRQ_ACK,
            bus.VECTOR, bus.IRQ_PEND}, 15'h0);
        bus.A = IEA;
        #1;
        chk("rst_ie", bus.DL_out, 8'hE0);
        nxt();
        bus.IRQ_TRIG = 5'h00;
        bus.RD       = 1'b0;
        bus.IME      = 1'b0;
        bus.ACK_REQ  = 1'b0;
        nxt();
        nRES = 1'b1;
        nxt();

        // register access vectors
        for (int i = 0; i < 12; i++) begin
            bus.A        = tbl[i].a;
            bus.WR       = tbl[i].wr;
            bus.RD       = tbl[i].rd;
            bus.DL_in    = tbl[i].dl;
            bus.IRQ_TRIG = tbl[i].trig;
            @(negedge CLK);
            chk($sformatf("tbl%0d", i),
                {bus.DL_out, bus.DL_oe, bus.IRQ_PEND},
                {tbl[i].e_dl, tbl[i].e_oe, tbl[i].e_pend});
            nxt();
        end
        bus.WR = 1'b0;
        bus.RD = 1'b0;

        // held request sets IF once only
        wr(IFA, 8'h00);
        bus.IRQ_TRIG = 5'h04;
        nxt();
        rd_chk("edge_set", IFA, 8'hE4);
        wr(IFA, 8'h00);
        repeat (5) nxt();
        rd_chk("edge_held", IFA, 8'hE0);
        bus.IRQ_TRIG = 5'h00;
        nxt();

        // priority and latency
        wr(IEA, 8'h1F);
        wr(IFA, 8'h14);
        bus.IME = 1'b1;
        kick();
        @(negedge CLK);
        chk("prio_n1", bus.ACK_VALID, 1'b0);
        nxt();
        @(negedge CLK);
        chk("prio_ack", {bus.ACK_VALID, bus.CPU_IRQ_ACK, bus.VECTOR},
            {1'b1, 5'h04, 8'h50});
        nxt();
        @(negedge CLK);
        chk("prio_n3", {bus.ACK_VALID, bus.CPU_IRQ_ACK, bus.VECTOR}, 14'h0);
        nxt();
        bus.IME = 1'b0;
        rd_chk("prio_if", IFA, 8'hF0);

        // IME gating
        wr(IFA, 8'h01);
        bus.ACK_REQ = 1'b1;
        acks = 0;
        @(negedge CLK);
        chk("gate_pend", bus.IRQ_PEND, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (bus.ACK_VALID) acks++;
        end
        chk("gate_noack", acks, 0);
        nxt();
        bus.ACK_REQ = 1'b0;

        // edge collides with dispatch clear
        bus.IME = 1'b1;
        kick();
        nxt();
        bus.IRQ_TRIG = 5'h01;
        @(negedge CLK);
        chk("coll_ack", {bus.ACK_VALID, bus.CPU_IRQ_ACK, bus.VECTOR},
            {1'b1, 5'h01, 8'h40});
        nxt();
        bus.IRQ_TRIG = 5'h00;
        bus.IME      = 1'b0;
        rd_chk("coll_if0", IFA, 8'hE1);
        bus.IRQ_TRIG = 5'h08;
        wr(IFA, 8'h00);
        bus.IRQ_TRIG = 5'h00;
        rd_chk("coll_if3", IFA, 8'hE8);

        // IE cleared during SAMPLE
        wr(IFA, 8'h04);
        bus.IME = 1'b1;
        kick();
        bus.A     = IEA;
        bus.DL_in = 8'h00;
        bus.WR    = 1'b1;
        nxt();
        bus.WR = 1'b0;
        @(negedge CLK);
`ifdef IRQ_CANCEL_EN
        chk("cancel", {bus.ACK_VALID, bus.CPU_IRQ_ACK, bus.VECTOR},
            {1'b1, 5'h00, 8'h00});
        nxt();
        bus.IME = 1'b0;
        rd_chk("cancel_if", IFA, 8'hE4);
`else
        chk("nocancel", {bus.ACK_VALID, bus.CPU_IRQ_ACK, bus.VECTOR},
            {1'b1, 5'h04, 8'h50});
        nxt();
        bus.IME = 1'b0;
        rd_chk("nocancel_if", IFA, 8'hE0);
`endif

        // random traffic against a rule-level model
        nRES = 1'b0;
        bus.IRQ_TRIG = 5'h00;
        nxt();
        nRES = 1'b1;
        mie = '0; mif = '0; mprev = '0;
        acc = -1; mw = -1;
        for (cyc = 0; cyc < 800; cyc++) begin
            case ($urandom_range(0, 3))
                0: bus.A = IEA;
                1: bus.A = IFA;
                2: bus.A = 16'($urandom);
                default: bus.A = IFA;
            endcase
            bus.WR    = ($urandom_range(0, 5) == 0);
            bus.RD    = $urandom_range(0, 1);
            bus.DL_in = 8'($urandom);
            if ($urandom_range(0, 2) == 0)
                bus.IRQ_TRIG = 5'($urandom);
            bus.IME     = ($urandom_range(0, 3) != 0);
            bus.ACK_REQ = ($urandom_range(0, 3) == 0);

            e_pend = |(mie & mif);
            e_ack  = (acc >= 0) && (cyc == acc + 2);
            if (acc >= 0 && cyc == acc + 1) mw = lowest(mie & mif);
`ifdef IRQ_CANCEL_EN
            d = lowest(mie & mif);
`else
            d = mw;
`endif
            e_oh  = (e_ack && d >= 0) ? 5'(1 << d) : 5'h00;
            e_vec = (e_ack && d >= 0) ? 8'(64 + d * 8) : 8'h00;
            e_dl  = (bus.A == IEA) ? {3'b111, mie}
                  : (bus.A == IFA) ? {3'b111, mif} : 8'h00;
            e_oe  = bus.RD && (bus.A == IEA || bus.A == IFA);

            @(negedge CLK);
            got = {bus.IRQ_PEND, bus.ACK_VALID, bus.CPU_IRQ_ACK,
                   bus.VECTOR, bus.DL_out, bus.DL_oe};
            exp = {e_pend, e_ack, e_oh, e_vec, e_dl, e_oe};
            chk($sformatf("rand%0d", cyc), got, exp);

            nif = (bus.WR && bus.A == IFA) ? bus.DL_in[4:0] : mif;
            if (e_ack && d >= 0) nif[d] = 1'b0;
            nif = nif | (bus.IRQ_TRIG & ~mprev);
            if (bus.WR && bus.A == IEA) mie = bus.DL_in[4:0];
            mif   = nif;
            mprev = bus.IRQ_TRIG;
            if (e_ack)
                acc = -1;
            else if (acc < 0 && bus.ACK_REQ && bus.IME && e_pend)
                acc = cyc;
            nxt();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
